ordering_table_mc: RTL

Parametrised multi-channel reorder table: accepts tagged requests, holds them until each is retired by ID, then releases them on the TX side. An ordered request additionally waits until every older request in its own channel has left. Requests in different channels never block one another. It sits between a request source and a completion/retire agent, and is the generalised, multi-channel successor of the single-domain 8-entry ordering table.

---
 rtl/ordering_table_mc_if.sv | 41 ++++
 rtl/ordering_table_mc.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ordering_table_mc_if.sv
// Request/retire/TX signal bundle for ordering_table_mc.
// The table itself connects through the slave modport; the request source and TX sink use master.
interface ordering_table_mc_if #(
  parameter int DEPTH  = 8,
  parameter int ID_W   = 3,
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
) ();
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              rx_valid_i;
  logic              rx_ready_o;
  logic [ID_W-1:0]   rx_id_i;
  logic [CH_W-1:0]   rx_ch_i;
  logic              rx_order_i;
  logic [DATA_W-1:0] rx_payload_i;
  logic              rx_ret_i;
  logic [ID_W-1:0]   rx_ret_id_i;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic [ID_W-1:0]   tx_id_o;
  logic [CH_W-1:0]   tx_ch_o;
  logic [DATA_W-1:0] tx_payload_o;
  logic [OCC_W-1:0]  occupancy_o;
  logic              ret_err_o;

  modport slave (
    input  rx_valid_i, rx_id_i, rx_ch_i, rx_order_i, rx_payload_i,
    input  rx_ret_i, rx_ret_id_i, tx_ready_i,
    output rx_ready_o, tx_valid_o, tx_id_o, tx_ch_o, tx_payload_o,
    output occupancy_o, ret_err_o
  );

  modport master (
    output rx_valid_i, rx_id_i, rx_ch_i, rx_order_i, rx_payload_i,
    output rx_ret_i, rx_ret_id_i, tx_ready_i,
    input  rx_ready_o, tx_valid_o, tx_id_o, tx_ch_o, tx_payload_o,
    input  occupancy_o, ret_err_o
  );
endinterface

// File: rtl/ordering_table_mc.sv
// Multi-channel reorder table: entries are held until retired by ID, then released oldest-first;
// ordered entries additionally wait for every older entry of their own channel to leave.
module ordering_table_mc #(
  parameter int DEPTH  = 8,
  parameter int ID_W   = 3,
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  ordering_table_mc_if.slave  bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  valid_q,   valid_d;
  logic [DEPTH-1:0]  retired_q, retired_d;
  logic [DEPTH-1:0]  ordered_q, ordered_d;
  logic [ID_W-1:0]   id_q      [DEPTH];
  logic [ID_W-1:0]   id_d      [DEPTH];
  logic [CH_W-1:0]   ch_q      [DEPTH];
  logic [CH_W-1:0]   ch_d      [DEPTH];
  logic [DATA_W-1:0] payload_q [DEPTH];
  logic [DATA_W-1:0] payload_d [DEPTH];
  logic [DEPTH-1:0]  older_q   [DEPTH];
  logic [DEPTH-1:0]  older_d   [DEPTH];
  logic              lock_q, lock_d;
  logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
  logic              ret_err_q, ret_err_d;

  logic [DEPTH-1:0]  ret_match;
  logic [DEPTH-1:0]  ret_hit;
  logic [DEPTH-1:0]  elig;
  logic [DEPTH-1:0]  pick;
  logic [DEPTH-1:0]  deq_onehot;
  logic [DEPTH-1:0]  same_ch [DEPTH];
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic [CH_W-1:0]   rx_ch_map;
  logic [OCC_W-1:0]  occ;
  logic              rx_ready;
  logic              accept;
  logic              deq;
  logic              tx_valid;

  assign rx_ready  = ~&valid_q;
  assign accept    = bus.rx_valid_i & rx_ready;
  assign rx_ch_map = (32'(bus.rx_ch_i) < NUM_CH) ? bus.rx_ch_i : '0;

  // older_q[i] is the set of entries older than i; a "nothing older within the
  // set" test therefore picks the single oldest member of any entry set.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      for (genvar gj = 0; gj < DEPTH; gj++) begin : g_peer
        assign same_ch[gi][gj] = valid_q[gj] & (ch_q[gj] == ch_q[gi]);
      end
      assign ret_match[gi] = bus.rx_ret_i & valid_q[gi] & ~retired_q[gi] &
                             (id_q[gi] == bus.rx_ret_id_i);
      assign ret_hit[gi]   = ret_match[gi] & ~|(older_q[gi] & ret_match);
      assign elig[gi]      = valid_q[gi] & retired_q[gi] &
                             (~ordered_q[gi] | ~|(older_q[gi] & same_ch[gi]));
      assign pick[gi]      = elig[gi] & ~|(older_q[gi] & elig);
    end
  endgenerate

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(valid_q[i]);
    end
  end

  // A stalled presentation stays locked even if an older entry becomes eligible.
  assign sel_idx    = lock_q ? lock_idx_q : pick_idx;
  assign tx_valid   = lock_q | (|pick);
  assign deq        = tx_valid & bus.tx_ready_i;
  assign deq_onehot = deq ? (DEPTH'(1) << sel_idx) : '0;

  always_comb begin
    valid_d    = valid_q & ~deq_onehot;
    retired_d  = retired_q | ret_hit;
    ordered_d  = ordered_q;
    lock_d     = tx_valid & ~bus.tx_ready_i;
    lock_idx_d = sel_idx;
    ret_err_d  = bus.rx_ret_i & ~|ret_match;
    for (int i = 0; i < DEPTH; i++) begin
      id_d[i]      = id_q[i];
      ch_d[i]      = ch_q[i];
      payload_d[i] = payload_q[i];
      older_d[i]   = older_q[i] & ~deq_onehot;
    end
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (IDX_W'(i) == free_idx) begin
          valid_d[i]   = 1'b1;
          retired_d[i] = 1'b0;
          ordered_d[i] = bus.rx_order_i;
          id_d[i]      = bus.rx_id_i;
          ch_d[i]      = rx_ch_map;
          payload_d[i] = bus.rx_payload_i;
          older_d[i]   = valid_q & ~deq_onehot;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= '0;
      retired_q  <= '0;
      ordered_q  <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      ret_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]      <= '0;
        ch_q[i]      <= '0;
        payload_q[i] <= '0;
        older_q[i]   <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      retired_q  <= retired_d;
      ordered_q  <= ordered_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      ret_err_q  <= ret_err_d;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]      <= id_d[i];
        ch_q[i]      <= ch_d[i];
        payload_q[i] <= payload_d[i];
        older_q[i]   <= older_d[i];
      end
    end
  end

  assign bus.rx_ready_o   = rx_ready;
  assign bus.occupancy_o  = occ;
  assign bus.ret_err_o    = ret_err_q;
  assign bus.tx_valid_o   = tx_valid;
  assign bus.tx_id_o      = tx_valid ? id_q[sel_idx]      : '0;
  assign bus.tx_ch_o      = tx_valid ? ch_q[sel_idx]      : '0;
  assign bus.tx_payload_o = tx_valid ? payload_q[sel_idx] : '0;
endmodule
